// File: rtl/sdram_arb_pkg.sv
// Shared types and default widths for the SDRAM arbiter slice.
package sdram_arb_pkg;
  localparam int ADDR_W_DEF = 26;
  localparam int DATA_W_DEF = 32;

  typedef enum logic {OWNER_VGA = 1'b0, OWNER_RAST = 1'b1} owner_t;
endpackage

// File: rtl/fifo.sv
// Generic synchronous FIFO, show-ahead read; 1-cycle write-to-read latency.
// Pushes while full and pops while empty are ignored; the caller owns flow control.
module fifo #(
  parameter int DBITS = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [DBITS-1:0] push_data,
  input  logic             pop,
  output logic [DBITS-1:0] pop_data,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);

  logic [DBITS-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + 1'b1;
      if (pop  && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign pop_data = mem[rd_ptr[AW-1:0]];
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
endmodule

// File: rtl/sdram_arbiter.sv
// Two-port Avalon-MM arbiter (VGA fixed priority, raster anti-starvation) onto one SDRAM master.
// Zero-cycle command and response paths; reads stall when the in-order tag FIFO is full.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int MAX_PENDING  = 16,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [ADDR_W-1:0]              p0_address,
  input  logic                           p0_read,
  output logic                           p0_waitrequest,
  output logic                           p0_readdatavalid,
  output logic [DATA_W-1:0]              p0_readdata,
  input  logic [ADDR_W-1:0]              p1_address,
  input  logic                           p1_read,
  input  logic                           p1_write,
  input  logic [DATA_W-1:0]              p1_writedata,
  output logic                           p1_waitrequest,
  output logic                           p1_readdatavalid,
  output logic [DATA_W-1:0]              p1_readdata,
  output logic [ADDR_W-1:0]              m_address,
  output logic                           m_read,
  output logic                           m_write,
  output logic [DATA_W-1:0]              m_writedata,
  input  logic                           m_waitrequest,
  input  logic                           m_readdatavalid,
  input  logic [DATA_W-1:0]              m_readdata,
  output logic [$clog2(MAX_PENDING):0]   pending_count,
  output logic                           err_orphan
);
  localparam int PW = $clog2(MAX_PENDING) + 1;
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic          req1, starve_max, sel0, sel1;
  logic          tag_full, tag_empty, push, pop, resp, acc1;
  owner_t        push_owner;
  logic [0:0]    head;
  logic [CW-1:0] starve_cnt;

  assign req1       = p1_read | p1_write;
  assign starve_max = (starve_cnt == CW'(STARVE_LIMIT));
  assign sel1       = req1 && (starve_max || !p0_read);
  assign sel0       = p0_read && !sel1;

  always_comb begin
    m_address      = p0_address;
    m_writedata    = p1_writedata;
    m_read         = 1'b0;
    m_write        = 1'b0;
    p0_waitrequest = 1'b1;
    p1_waitrequest = 1'b1;
    if (reset) begin
      if (sel1) begin
        m_address      = p1_address;
        m_read         = p1_read && !tag_full;
        m_write        = p1_write;
        p1_waitrequest = m_waitrequest || (p1_read && tag_full);
      end else if (sel0) begin
        m_read         = !tag_full;
        p0_waitrequest = m_waitrequest || tag_full;
      end
    end
  end

  // Only reads are tagged; writes produce no response.
  assign push       = m_read && !m_waitrequest;
  assign push_owner = sel1 ? OWNER_RAST : OWNER_VGA;
  assign acc1       = sel1 && (m_read || m_write) && !m_waitrequest;

  assign resp = reset && m_readdatavalid;
  assign pop  = resp && !tag_empty;

  assign p0_readdatavalid = pop && (head == OWNER_VGA);
  assign p1_readdatavalid = pop && (head == OWNER_RAST);
  assign p0_readdata      = m_readdata;
  assign p1_readdata      = m_readdata;

  fifo #(
    .DBITS (1),
    .DEPTH (MAX_PENDING)
  ) u_tag_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_owner),
    .pop       (pop),
    .pop_data  (head),
    .empty     (tag_empty),
    .full      (tag_full)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_count <= '0;
      starve_cnt    <= '0;
      err_orphan    <= 1'b0;
    end else begin
      pending_count <= pending_count + PW'(push) - PW'(pop);
      if (resp && tag_empty) err_orphan <= 1'b1;
      // Saturating at the limit keeps port 1 selected until it is finally accepted.
      if (!req1 || acc1)    starve_cnt <= '0;
      else if (!starve_max) starve_cnt <= starve_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboard bench for sdram_arbiter: expected responses queued on accept, checked by a monitor.
module tb_sdram_arbiter;
  localparam int AW = 26;
  localparam int DW = 32;

  typedef struct packed {
    logic          owner;
    logic [DW-1:0] data;
  } exp_t;

  typedef struct packed {
    int            due;
    logic [DW-1:0] data;
  } sd_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] p0_address, p1_address, m_address;
  logic          p0_read, p0_waitrequest, p0_readdatavalid;
  logic [DW-1:0] p0_readdata, p1_readdata, p1_writedata, m_writedata, m_readdata;
  logic          p1_read, p1_write, p1_waitrequest, p1_readdatavalid;
  logic          m_read, m_write, m_waitrequest, m_readdatavalid;
  logic [4:0]    pending_count;
  logic          err_orphan;

  logic          md_vld = 1'b0, man_vld = 1'b0;
  logic [DW-1:0] md_dat = '0, man_dat = '0;
  logic          sd_en = 1'b1, sd_hold = 1'b0;
  int            cyc = 0;
  int            checks = 0, failures = 0;
  logic          p0_acc, p1r_acc, p1w_acc;

  exp_t          exp_q[$];
  sd_t           sd_q[$];
  logic [DW-1:0] ovr_q[$];

  assign m_readdatavalid = md_vld | man_vld;
  assign m_readdata      = man_vld ? man_dat : md_dat;

  sdram_arbiter dut (
    .clk(clk), .reset(reset),
    .p0_address(p0_address), .p0_read(p0_read), .p0_waitrequest(p0_waitrequest),
    .p0_readdatavalid(p0_readdatavalid), .p0_readdata(p0_readdata),
    .p1_address(p1_address), .p1_read(p1_read), .p1_write(p1_write),
    .p1_writedata(p1_writedata), .p1_waitrequest(p1_waitrequest),
    .p1_readdatavalid(p1_readdatavalid), .p1_readdata(p1_readdata),
    .m_address(m_address), .m_read(m_read), .m_write(m_write), .m_writedata(m_writedata),
    .m_waitrequest(m_waitrequest), .m_readdatavalid(m_readdatavalid), .m_readdata(m_readdata),
    .pending_count(pending_count), .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] fdat(logic [AW-1:0] a);
    return 32'hC0DE_0000 ^ {6'd0, a};
  endfunction

  task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] next_exp(logic [AW-1:0] a);
    if (ovr_q.size() > 0) return ovr_q.pop_front();
    return fdat(a);
  endfunction

  // SDRAM model: fixed 3-cycle read latency, responses can be withheld.
  always @(negedge clk)
    if (sd_en && m_read && !m_waitrequest) sd_q.push_back('{due: cyc + 3, data: fdat(m_address)});

  always @(posedge clk) begin
    #1;
    if (!sd_hold && sd_q.size() > 0 && sd_q[0].due <= cyc) begin
      md_vld = 1'b1;
      md_dat = sd_q[0].data;
      void'(sd_q.pop_front());
    end else begin
      md_vld = 1'b0;
    end
  end

  // Response monitor.
  always @(negedge clk) begin
    if (p0_readdatavalid || p1_readdatavalid) begin
      exp_t e;
      chk("rsp_onehot", {31'd0, p0_readdatavalid & p1_readdatavalid}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rsp_unexpected: p0_rdv=%0b p1_rdv=%0b with no expected read (cycle %0d)",
                 p0_readdatavalid, p1_readdatavalid, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_owner", {31'd0, p1_readdatavalid}, {31'd0, e.owner});
        chk("rsp_data", e.owner ? p1_readdata : p0_readdata, e.data);
      end
    end
  end

  task automatic sample();
    @(negedge clk);
    p0_acc  = p0_read && !p0_waitrequest;
    p1r_acc = p1_read && !p1_waitrequest;
    p1w_acc = p1_write && !p1_waitrequest;
    if (p0_acc)  exp_q.push_back('{owner: 1'b0, data: next_exp(p0_address)});
    if (p1r_acc) exp_q.push_back('{owner: 1'b1, data: next_exp(p1_address)});
  endtask

  task automatic adv();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(int n);
    repeat (n) begin sample(); adv(); end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish within time budget");
    $fatal(1, "timeout");
  end

  initial begin
    int peak, n, slot;
    logic got;
    reset = 1'b0; m_waitrequest = 1'b0;
    p0_address = 26'h100; p0_read = 1'b1;
    p1_address = 26'h800; p1_read = 1'b0; p1_write = 1'b1; p1_writedata = 32'h1000_0000;
    #12;
    chk("rst_m_read", {31'd0, m_read}, 32'd0);
    chk("rst_m_write", {31'd0, m_write}, 32'd0);
    chk("rst_p0_wait", {31'd0, p0_waitrequest}, 32'd1);
    chk("rst_p1_wait", {31'd0, p1_waitrequest}, 32'd1);
    chk("rst_pending", {27'd0, pending_count}, 32'd0);
    chk("rst_orphan", {31'd0, err_orphan}, 32'd0);
    p0_read = 1'b0; p1_write = 1'b0;
    @(posedge clk); #2; reset = 1'b1;

    // 1: streaming VGA reads with 3-cycle memory latency.
    p0_read = 1'b1; peak = 0;
    repeat (12) begin
      sample();
      if (int'(pending_count) > peak) peak = int'(pending_count);
      adv();
      if (p0_acc) p0_address += 8;
    end
    p0_read = 1'b0;
    idle(6);
    chk("t1_peak", peak, 32'd3);
    chk("t1_drained", exp_q.size(), 32'd0);

    // 2: VGA saturating the bus; raster writes forced through once per 9 cycles.
    p0_read = 1'b1; p1_write = 1'b1; n = 0;
    for (int i = 0; i < 27; i++) begin
      sample();
      if (p1w_acc) begin
        n++;
        chk("t2_wdata", m_writedata, p1_writedata);
        slot = i % 9;
        chk("t2_slot", slot, 32'd8);
      end
      adv();
      if (p0_acc) p0_address += 8;
      if (p1w_acc) p1_writedata += 1;
    end
    p0_read = 1'b0; p1_write = 1'b0;
    chk("t2_count", n, 32'd3);
    idle(6);

    // 3: interleaved owners with directed response data.
    sd_en = 1'b0;
    ovr_q.push_back(32'hA); ovr_q.push_back(32'hB); ovr_q.push_back(32'hC);
    m_waitrequest = 1'b1; p0_read = 1'b1; p0_address = 26'h200;
    sample(); chk("t3_mwait", {31'd0, p0_waitrequest}, 32'd1); adv();
    m_waitrequest = 1'b0;
    sample(); adv();
    p0_read = 1'b0; p1_read = 1'b1; p1_address = 26'h300;
    sample(); adv();
    p1_read = 1'b0; p0_read = 1'b1; p0_address = 26'h208;
    sample(); adv();
    p0_read = 1'b0;
    chk("t3_pending", {27'd0, pending_count}, 32'd3);
    man_vld = 1'b1; man_dat = 32'hA; sample(); adv();
    man_dat = 32'hB; sample(); adv();
    man_dat = 32'hC; sample(); adv();
    man_vld = 1'b0;
    idle(2);
    chk("t3_drained", exp_q.size(), 32'd0);
    sd_en = 1'b1;

    // 4: tag FIFO full stalls reads but not writes.
    sd_hold = 1'b1; p0_read = 1'b1; p0_address = 26'h400;
    repeat (16) begin
      sample(); adv();
      if (p0_acc) p0_address += 8;
    end
    sample();
    chk("t4_full_wait", {31'd0, p0_waitrequest}, 32'd1);
    chk("t4_full_mread", {31'd0, m_read}, 32'd0);
    chk("t4_full_count", {27'd0, pending_count}, 32'd16);
    adv();
    p1_write = 1'b1; p1_writedata = 32'h5555_AAAA; got = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      sample();
      if (p1w_acc) begin
        got = 1'b1;
        chk("t4_wr_mwrite", {31'd0, m_write}, 32'd1);
        chk("t4_wr_pending", {27'd0, pending_count}, 32'd16);
      end
      adv();
    end
    chk("t4_wr_accepted", {31'd0, got}, 32'd1);
    p1_write = 1'b0;
    sd_hold = 1'b0; sample(); adv(); sd_hold = 1'b1;
    sample();
    chk("t4_resp", {31'd0, m_readdatavalid}, 32'd1);
    chk("t4_still_full", {31'd0, p0_waitrequest}, 32'd0 + 32'd1);
    adv();
    sample();
    chk("t4_freed", {31'd0, p0_waitrequest}, 32'd0);
    chk("t4_freed_mread", {31'd0, m_read}, 32'd1);
    adv();
    if (p0_acc) p0_address += 8;
    p0_read = 1'b0; sd_hold = 1'b0;
    idle(25);
    chk("t4_drained", exp_q.size(), 32'd0);
    chk("t4_pending0", {27'd0, pending_count}, 32'd0);

    // 5: orphan response.
    chk("t5_orphan_pre", {31'd0, err_orphan}, 32'd0);
    man_vld = 1'b1; man_dat = 32'hDEAD;
    sample();
    chk("t5_no_rdv", {30'd0, p0_readdatavalid, p1_readdatavalid}, 32'd0);
    adv();
    man_vld = 1'b0;
    sample(); chk("t5_orphan", {31'd0, err_orphan}, 32'd1); adv();
    idle(4);
    chk("t5_orphan_sticky", {31'd0, err_orphan}, 32'd1);

    // 6: reset with reads outstanding; late responses become orphans.
    sd_hold = 1'b1; p0_read = 1'b1; p0_address = 26'h600;
    repeat (5) begin
      sample(); adv();
      if (p0_acc) p0_address += 8;
    end
    chk("t6_pending", {27'd0, pending_count}, 32'd5);
    #1 reset = 1'b0;
    #1;
    chk("t6_m_read", {31'd0, m_read}, 32'd0);
    chk("t6_p0_wait", {31'd0, p0_waitrequest}, 32'd1);
    chk("t6_p1_wait", {31'd0, p1_waitrequest}, 32'd1);
    chk("t6_pending_rst", {27'd0, pending_count}, 32'd0);
    chk("t6_orphan_rst", {31'd0, err_orphan}, 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1; p0_read = 1'b0; sd_hold = 1'b0;
    idle(8);
    chk("t6_late_orphan", {31'd0, err_orphan}, 32'd1);
    chk("t6_pending_end", {27'd0, pending_count}, 32'd0);
    chk("end_queue_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
